// File: rtl/modbus_rx_framer.sv
// Modbus RTU receive framer: silence-delimited framing, CRC streaming, frame buffer, end-of-frame status.
// Bytes reach crc_* one cycle after rx_valid; status pulses T35_CLKS+1 cycles after the last byte; no backpressure.
module modbus_rx_framer #(
  parameter int T15_CLKS  = 42969,
  parameter int T35_CLKS  = 100261,
  parameter int MAX_BYTES = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_err,
  input  logic [7:0]                   dev_addr,
  output logic                         crc_en,
  output logic                         crc_clr,
  output logic [7:0]                   crc_data,
  input  logic [15:0]                  crc_in,
  output logic                         frame_done,
  output logic                         frame_ok,
  output logic                         frame_bcast,
  output logic [3:0]                   frame_err,
  output logic [8:0]                   frame_len,
  input  logic                         frame_ack,
  input  logic [$clog2(MAX_BYTES)-1:0] rd_addr,
  output logic [7:0]                   rd_data
);
  localparam int AW = $clog2(MAX_BYTES);
  localparam int TW = $clog2(T35_CLKS + 1);
  // r_timer holds (cycles since last byte - 1), hence the offset thresholds
  localparam logic [TW-1:0] T15_M1  = TW'(T15_CLKS - 1);
  localparam logic [TW-1:0] T35_M2  = TW'(T35_CLKS - 2);
  localparam logic [TW-1:0] T35_SAT = TW'(T35_CLKS);
  localparam logic [8:0]    LEN_MAX = 9'(MAX_BYTES);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RX, S_CHECK, S_HOLD} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [8:0]      r_len;
  logic [7:0]      r_addr;
  logic            r_ovf;
  logic            r_gap;
  logic            r_uart;
  logic            r_resync;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_mem [MAX_BYTES];

  logic            w_quiet;
  logic            w_full;
  logic            w_accept;
  logic            w_first;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic            w_crc_bad;
  logic            w_addr_hit;

  assign w_quiet    = (r_timer >= T35_M2) && !rx_valid;
  assign w_full     = (r_len >= LEN_MAX);
  assign w_crc_bad  = (crc_in != 16'h0000) || (r_len < 9'd4);
  assign w_addr_hit = (r_addr == dev_addr) || (r_addr == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_first   = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    case (r_state)
      S_INIT: if (w_quiet) w_next = S_IDLE;
      S_IDLE: begin
        w_accept = rx_valid;
        w_first  = rx_valid;
        w_wr_en  = rx_valid;
        if (rx_valid) w_next = S_RX;
      end
      S_RX: begin
        w_accept  = rx_valid;
        w_wr_en   = rx_valid && !w_full;
        w_wr_addr = r_len[AW-1:0];
        if (w_quiet) w_next = S_CHECK;
      end
      S_CHECK: w_next = S_HOLD;
      // a byte seen together with the ack still means the line is mid-frame
      S_HOLD: if (frame_ack) w_next = (r_resync || rx_valid) ? S_INIT : S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_ovf       <= 1'b0;
      r_gap       <= 1'b0;
      r_uart      <= 1'b0;
      r_resync    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      crc_en      <= 1'b0;
      crc_clr     <= 1'b0;
      crc_data    <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bcast <= 1'b0;
      frame_err   <= '0;
      frame_len   <= '0;
      rd_data     <= '0;
    end else begin
      if (rx_valid)                r_timer <= '0;
      else if (r_timer != T35_SAT) r_timer <= r_timer + 1'b1;

      crc_en     <= w_accept;
      if (w_accept) crc_data <= rx_data;
      crc_clr    <= (r_state == S_HOLD) && frame_ack;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      frame_done <= (r_state == S_CHECK);

      if (w_first) begin
        r_len  <= 9'd1;
        r_addr <= rx_data;
        r_ovf  <= 1'b0;
        r_gap  <= 1'b0;
        r_uart <= rx_err;
      end else if ((r_state == S_RX) && rx_valid) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_len <= r_len + 9'd1;
        if (r_timer >= T15_M1) r_gap <= 1'b1;
        if (rx_err) r_uart <= 1'b1;
      end

      if (r_state == S_CHECK) begin
        frame_len   <= r_len;
        frame_bcast <= (r_addr == 8'h00);
        frame_err   <= {r_ovf, r_gap, r_uart, w_crc_bad};
        frame_ok    <= !(r_ovf || r_gap || r_uart || w_crc_bad) && w_addr_hit;
        r_resync    <= 1'b0;
      end else if ((r_state == S_HOLD) && rx_valid) begin
        r_resync <= 1'b1;
      end

      rd_data <= r_mem[rd_addr];
    end
  end

  // Write data is the registered CRC byte: same byte, same cycle
  always_ff @(posedge clk) begin
    if (r_wr_en) r_mem[r_wr_addr] <= crc_data;
  end
endmodule

// File: tb/tb_modbus_rx_framer.sv
// Bench for modbus_rx_framer: table vectors, corner sequences and random frames vs. a frame-level model.
module tb_modbus_rx_framer;
  localparam int T15  = 15;
  localparam int T35  = 35;
  localparam int MAXB = 256;
  localparam int CHAR = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_err = 1'b0;
  logic [7:0]  dev_addr = 8'h01;
  logic        crc_en, crc_clr;
  logic [7:0]  crc_data;
  logic [15:0] crc_q;
  logic        frame_done, frame_ok, frame_bcast;
  logic [3:0]  frame_err;
  logic [8:0]  frame_len;
  logic        frame_ack = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  modbus_rx_framer #(.T15_CLKS(T15), .T35_CLKS(T35), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .dev_addr(dev_addr), .crc_en(crc_en), .crc_clr(crc_clr), .crc_data(crc_data),
    .crc_in(crc_q), .frame_done(frame_done), .frame_ok(frame_ok), .frame_bcast(frame_bcast),
    .frame_err(frame_err), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // External CRC-16 engine
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_q <= 16'hFFFF;
    else if (crc_clr) crc_q <= 16'hFFFF;
    else if (crc_en)  crc_q <= crc_step(crc_q, crc_data);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_en    = 0;
  int n_clash = 0;
  always @(posedge clk) begin
    if (frame_done) n_done++;
    if (crc_en) n_en++;
    if (crc_en && crc_clr) n_clash++;
  end

  logic [7:0] fq[$];
  int         fsp[$];
  logic       fer[$];

  typedef struct {
    logic [7:0]      dev;
    int              n;
    logic [0:7][7:0] b;
    int              gap_at;
    int              gap_len;
    int              err_at;
    logic            fix;
    logic [1:0]      ack_mode;
    logic            exp_ok;
    logic [3:0]      exp_err;
    int              exp_len;
    logic            exp_bc;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = e;
    tick();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic load_f();
    logic [0:7][7:0] f;
    f = 64'h01030000_0001840A;
    fq.delete(); fsp.delete(); fer.delete();
    for (int i = 0; i < 8; i++) begin
      fq.push_back(f[i]); fsp.push_back(CHAR); fer.push_back(1'b0);
    end
  endtask

  task automatic fix_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < fq.size() - 2; i++) c = crc_step(c, fq[i]);
    fq[fq.size()-2] = c[7:0];
    fq[fq.size()-1] = c[15:8];
  endtask

  // Frame-level reference: status derived directly from the byte list, spacings and error marks
  task automatic model(input logic [7:0] dev, output logic ok, output logic [3:0] err,
                       output int len, output logic bc);
    logic [15:0] c;
    logic gap, ua, ovf, cb;
    c = 16'hFFFF; gap = 1'b0; ua = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      c = crc_step(c, fq[i]);
      if (i > 0 && fsp[i] >= T15) gap = 1'b1;
      if (fer[i]) ua = 1'b1;
    end
    ovf = (fq.size() > MAXB);
    len = ovf ? MAXB : fq.size();
    cb  = (c != 16'h0000) || (fq.size() < 4);
    err = {ovf, gap, ua, cb};
    bc  = (fq[0] == 8'h00);
    ok  = (err == 4'h0) && ((fq[0] == dev) || (fq[0] == 8'h00));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " crc_en"}, crc_en, 0);
    check({tag, " crc_clr"}, crc_clr, 0);
    check({tag, " crc_data"}, crc_data, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " frame_ok"}, frame_ok, 0);
    check({tag, " frame_bcast"}, frame_bcast, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " frame_len"}, frame_len, 0);
    check({tag, " rd_data"}, rd_data, 0);
  endtask

  task automatic ack_pulse(input string tag);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    @(negedge clk);
    check({tag, " crc_clr"}, crc_clr, 1);
    check({tag, " crc_en_vs_clr"}, crc_en, 0);
    tick();
  endtask

  // ack_mode: 0 = readback then ack, 1 = ack in the frame_done cycle, 2 = leave in HOLD
  task automatic run_frame(input string tag, input logic [1:0] ack_mode, input logic exp_ok,
                           input logic [3:0] exp_err, input int exp_len, input logic exp_bc);
    int d0, e0, lat, nrd;
    logic found;
    d0 = n_done; e0 = n_en; lat = 0; found = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      if (i > 0) idle(fsp[i] - 1);
      send_byte(fq[i], fer[i]);
    end
    for (int k = 1; k <= T35 + 20 && !found; k++) begin
      @(negedge clk);
      if (frame_done) begin found = 1'b1; lat = k; end
    end
    check({tag, " done_latency"}, lat, T35 + 1);
    check({tag, " frame_ok"}, frame_ok, exp_ok);
    check({tag, " frame_err"}, frame_err, exp_err);
    check({tag, " frame_len"}, frame_len, exp_len);
    check({tag, " frame_bcast"}, frame_bcast, exp_bc);
    check({tag, " crc_en_count"}, n_en - e0, fq.size());
    if (ack_mode == 2'd1) begin
      frame_ack = 1'b1;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
      @(negedge clk);
      check({tag, " crc_clr_same_cycle_ack"}, crc_clr, 1);
      tick();
    end else begin
      tick();
      if (ack_mode == 2'd0) begin
        nrd = (fq.size() > MAXB) ? MAXB : fq.size();
        for (int i = 0; i < nrd; i++) begin
          rd_addr = 8'(i);
          tick();
          @(negedge clk);
          check($sformatf("%s rd%0d", tag, i), rd_data, fq[i]);
        end
        tick();
        ack_pulse(tag);
      end
    end
    idle(2);
    check({tag, " done_count"}, n_done - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic ok_e, bc_e;
    logic [3:0] err_e;
    int len_e, e0;

    tbl[0]  = '{8'h01, 8, 64'h01030000_0001840A, -1, 0, -1, 1'b0, 2'd0, 1'b1, 4'h0, 8, 1'b0};
    tbl[1]  = '{8'h01, 8, 64'h01030000_0001840B, -1, 0, -1, 1'b0, 2'd1, 1'b0, 4'h1, 8, 1'b0};
    tbl[2]  = '{8'h02, 8, 64'h01030000_0001840A, -1, 0, -1, 1'b0, 2'd1, 1'b0, 4'h0, 8, 1'b0};
    tbl[3]  = '{8'h01, 8, 64'h01030000_0001840A, 3, 2*T15, -1, 1'b0, 2'd1, 1'b0, 4'h4, 8, 1'b0};
    tbl[4]  = '{8'h01, 8, 64'h01030000_0001840A, 3, T15-1, -1, 1'b0, 2'd1, 1'b1, 4'h0, 8, 1'b0};
    tbl[5]  = '{8'h01, 8, 64'h01030000_0001840A, 3, T15, -1, 1'b0, 2'd0, 1'b0, 4'h4, 8, 1'b0};
    tbl[6]  = '{8'h01, 8, 64'h01030000_0001840A, -1, 0, 2, 1'b0, 2'd1, 1'b0, 4'h2, 8, 1'b0};
    tbl[7]  = '{8'h01, 8, 64'h00060001_00030000, -1, 0, -1, 1'b1, 2'd0, 1'b1, 4'h0, 8, 1'b1};
    tbl[8]  = '{8'h01, 2, 64'h01030000_00000000, -1, 0, -1, 1'b0, 2'd1, 1'b0, 4'h1, 2, 1'b0};
    tbl[9]  = '{8'h01, 3, 64'h01000000_00000000, -1, 0, -1, 1'b1, 2'd1, 1'b0, 4'h1, 3, 1'b0};
    tbl[10] = '{8'h01, 4, 64'h01070000_00000000, -1, 0, -1, 1'b1, 2'd0, 1'b1, 4'h0, 4, 1'b0};
    tbl[11] = '{8'h01, 8, 64'h11030000_00010000, -1, 0, -1, 1'b1, 2'd1, 1'b0, 4'h0, 8, 1'b0};

    // Reset values, then a stray byte during initial silence
    idle(3);
    @(negedge clk);
    check_reset("reset");
    tick();
    rst_n = 1'b1;
    idle(9);
    send_byte(8'h55, 1'b0);
    idle(T35 - 1);
    load_f();
    run_frame("startup", 2'd0, 1'b1, 4'h0, 8, 1'b0);

    for (int v = 0; v < NV; v++) begin
      idle(3);
      dev_addr = tbl[v].dev;
      fq.delete(); fsp.delete(); fer.delete();
      for (int i = 0; i < tbl[v].n; i++) begin
        fq.push_back(tbl[v].b[i]);
        fsp.push_back((i == tbl[v].gap_at) ? tbl[v].gap_len : CHAR);
        fer.push_back(i == tbl[v].err_at);
      end
      if (tbl[v].fix) fix_crc();
      run_frame($sformatf("vec%0d", v), tbl[v].ack_mode, tbl[v].exp_ok, tbl[v].exp_err,
                tbl[v].exp_len, tbl[v].exp_bc);
    end

    for (int r = 0; r < 12; r++) begin
      int n, sel;
      logic [7:0] dv;
      idle(3);
      n  = $urandom_range(1, 20);
      dv = 8'($urandom_range(1, 247));
      sel = $urandom_range(0, 3);
      fq.delete(); fsp.delete(); fer.delete();
      for (int i = 0; i < n; i++) begin
        fq.push_back(8'($urandom_range(0, 255)));
        fsp.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(T15 - 1, T15 + 3)
                                                  : $urandom_range(1, 12));
        fer.push_back($urandom_range(0, 15) == 0);
      end
      fq[0] = (sel == 2) ? 8'h00 : (sel == 3) ? fq[0] : dv;
      if (n >= 3 && $urandom_range(0, 3) != 0) fix_crc();
      dev_addr = dv;
      model(dv, ok_e, err_e, len_e, bc_e);
      run_frame($sformatf("rand%0d", r), 2'($urandom_range(0, 1)), ok_e, err_e, len_e, bc_e);
    end

    // Overflow: 260 bytes into a 256-byte buffer
    idle(3);
    dev_addr = 8'h01;
    fq.delete(); fsp.delete(); fer.delete();
    for (int i = 0; i < 260; i++) begin
      fq.push_back(8'($urandom_range(0, 255)));
      fsp.push_back(CHAR);
      fer.push_back(1'b0);
    end
    fq[0] = 8'h01;
    model(8'h01, ok_e, err_e, len_e, bc_e);
    run_frame("ovf", 2'd0, ok_e, err_e, len_e, bc_e);
    check("ovf len_sat", frame_len, 256);
    check("ovf err_bit", frame_err[3], 1);
    check("ovf ok", frame_ok, 0);

    // Bytes during HOLD force resync through INIT
    idle(3);
    load_f();
    run_frame("hold_pre", 2'd2, 1'b1, 4'h0, 8, 1'b0);
    e0 = n_en;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hA0 + 8'(k), 1'b0);
      idle(CHAR - 1);
    end
    check("hold crc_en_count", n_en - e0, 0);
    check("hold len_frozen", frame_len, 8);
    ack_pulse("hold");
    idle(2);
    send_byte(8'h77, 1'b0);
    idle(T35 - 1);
    load_f();
    run_frame("resync", 2'd0, 1'b1, 4'h0, 8, 1'b0);

    // Reset mid-frame
    idle(3);
    load_f();
    e0 = n_done;
    for (int i = 0; i < 3; i++) begin
      send_byte(fq[i], 1'b0);
      idle(CHAR - 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    tick();
    rst_n = 1'b1;
    idle(T35 + 10);
    check("midrst no_done", n_done - e0, 0);
    load_f();
    run_frame("post_rst", 2'd0, 1'b1, 4'h0, 8, 1'b0);

    check("crc_en_clr_overlap", n_clash, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
